// File: rtl/flit_pop_stage.sv
// flit_pop_stage: drains a flit_buffer onto a valid/ready stream.
// Two-entry skid (head/spare) hides the buffer's one-cycle read latency.
module flit_pop_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  buf_not_empty,
  output logic                  buf_rd_en,
  input  logic [DATA_WIDTH-1:0] buf_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_count
);

  logic                  r_hv;
  logic                  r_sv;
  logic                  r_inf;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_spare;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic       w_pop;
  logic       w_arr;
  logic [1:0] w_load;
  logic [1:0] w_room;

  assign out_valid = r_hv;
  assign out_data  = r_head;
  assign out_count = r_cnt;

  // Pop/arrival and read issue; out_ready feeds rd_en for full rate
  always_comb begin
    w_pop  = r_hv & out_ready;
    w_arr  = r_inf & ~flush;
    w_load = {1'b0, r_hv} + {1'b0, r_sv} + {1'b0, r_inf};
    w_room = {1'b0, w_pop} + 2'd1;
    buf_rd_en = rst_n & buf_not_empty & ~flush
              & (w_load <= w_room);
  end

  // Skid store, in-flight tracking and delivered counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hv    <= 1'b0;
      r_sv    <= 1'b0;
      r_inf   <= 1'b0;
      r_head  <= '0;
      r_spare <= '0;
      r_cnt   <= '0;
    end else begin
      r_inf <= buf_rd_en;
      if (w_pop) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      if (flush) begin
        r_hv <= 1'b0;
        r_sv <= 1'b0;
      end else begin
        unique case (1'b1)
          w_arr & ~r_hv: begin
            r_head <= buf_data;
            r_hv   <= 1'b1;
          end
          w_arr & r_hv & ~r_sv & w_pop: begin
            r_head <= buf_data;
          end
          w_arr & r_hv & ~r_sv & ~w_pop: begin
            r_spare <= buf_data;
            r_sv    <= 1'b1;
          end
          w_arr & r_hv & r_sv: begin
            r_head  <= r_spare;
            r_spare <= buf_data;
          end
          ~w_arr & w_pop & r_sv: begin
            r_head <= r_spare;
            r_sv   <= 1'b0;
          end
          ~w_arr & w_pop & ~r_sv: begin
            r_hv <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flit_pop_stage.sv
// tb_flit_pop_stage: scoreboard bench for flit_pop_stage.
// A small flit_buffer model feeds the stage; a monitor checks pops.
module tb_flit_pop_stage;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          buf_not_empty;
  logic          buf_rd_en;
  logic [DW-1:0] buf_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_count;

  flit_pop_stage #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buf_not_empty(buf_not_empty),
    .buf_rd_en    (buf_rd_en),
    .buf_data     (buf_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_count    (out_count)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_q[$];

  // buffer model: registered read, same reset as the stage
  logic [DW-1:0] mem[256];
  logic [7:0]    wp;
  logic [7:0]    rp;

  assign buf_not_empty = (wp != rp);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp       <= '0;
      buf_data <= '0;
    end else if (buf_rd_en) begin
      buf_data <= mem[rp];
      rp       <= rp + 8'd1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h",
               nm, act, req);
    end
  endtask

  task automatic put(input logic [DW-1:0] d);
    mem[wp] = d;
    wp = wp + 8'd1;
    exp_q.push_back(d);
  endtask

  // monitor: pops, ordering, occupancy model
  int          b_held = 0;
  int          b_inf  = 0;
  logic [CW-1:0] m_cnt = '0;
  bit          m_pop;
  bit          m_arr;
  int          m_nd;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      b_held = 0;
      b_inf  = 0;
      m_cnt  = '0;
    end else begin
      m_pop = out_valid & out_ready;
      m_arr = (b_inf != 0) && !flush;
      chk("valid_vs_model", {31'd0, out_valid},
          {31'd0, b_held != 0});
      if (buf_rd_en)
        chk("rd_when_empty", {31'd0, buf_not_empty}, 1);
      if (flush)
        chk("rd_in_flush", {31'd0, buf_rd_en}, 0);
      if (m_arr)
        chk("arrive_full_no_pop",
            {31'd0, b_held == 2 && !m_pop}, 0);
      if (m_pop) begin
        chk("count", {28'd0, out_count}, {28'd0, m_cnt});
        m_cnt = m_cnt + 4'd1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %0h required none",
                   out_data);
        end else begin
          chk("data", out_data, exp_q.pop_front());
        end
      end
      if (flush) begin
        m_nd = b_held - (m_pop ? 1 : 0) + b_inf;
        repeat (m_nd)
          if (exp_q.size() > 0) exp_q.delete(0);
        b_held = 0;
        b_inf  = 0;
      end else begin
        b_held = b_held + (m_arr ? 1 : 0) - (m_pop ? 1 : 0);
        b_inf  = buf_rd_en ? 1 : 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    wp        = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  int n;
  int rdc;

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    wp        = '0;
    #2;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", {28'd0, out_count}, 0);
    chk("rst_rd_en", {31'd0, buf_rd_en}, 0);

    // streaming
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) put(32'h10 + i);
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (buf_rd_en) break;
      n++;
    end
    chk("first_rd_seen", {31'd0, buf_rd_en}, 1);
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk("latency", n, 2);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("stream_gap", {31'd0, out_valid}, 1);
    end
    @(negedge clk);
    chk("stream_end", {31'd0, out_valid}, 0);
    chk("stream_count", {28'd0, out_count}, 8);

    // stall with full skid
    do_reset();
    for (int i = 0; i < 5; i++) put(32'h20 + i);
    rdc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (buf_rd_en) rdc++;
      if (out_valid) chk("stall_hold", out_data, 32'h20);
    end
    chk("stall_rd_pulses", rdc, 2);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("resume_gap", {31'd0, out_valid}, 1);
    end
    @(negedge clk);
    chk("resume_end", {31'd0, out_valid}, 0);
    chk("resume_count", {28'd0, out_count}, 5);

    // alternating backpressure
    do_reset();
    for (int i = 0; i < 16; i++) put(32'h30 + i);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    drain();

    // flush with held and in-flight flits
    do_reset();
    for (int i = 0; i < 5; i++) put(32'h40 + i);
    repeat (6) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    flush     = 1'b1;
    @(negedge clk);
    chk("flush_rd_en", {31'd0, buf_rd_en}, 0);
    chk("flush_head", out_data, 32'h41);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("post_flush_valid", {31'd0, out_valid}, 0);
    chk("post_flush_count", {28'd0, out_count}, 1);
    out_ready = 1'b1;
    drain();
    chk("flush_final_count", {28'd0, out_count}, 3);

    // counter wrap
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) put(32'h50 + i);
    drain();
    chk("wrap_count", {28'd0, out_count}, 1);

    // asynchronous reset mid-stream
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) put(32'h70 + i);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    wp    = '0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 0);
    chk("arst_data", out_data, 0);
    chk("arst_count", {28'd0, out_count}, 0);
    chk("arst_rd_en", {31'd0, buf_rd_en}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) put(32'hA0 + i);
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    chk("arst_first", out_data, 32'hA0);
    drain();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
